// File: rtl/tthbif_cfg_pkg.sv
// Shared constants and FSM state type for the tthbif lane-tap configuration parser.
package tthbif_cfg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  localparam logic [7:0] ID_VALUE = 8'hA5;

  localparam logic [7:0] ADDR_RX_FLOP_SEL = 8'h00;
  localparam logic [7:0] ADDR_RX_COMB_SEL = 8'h01;
  localparam logic [7:0] ADDR_TX_FLOP_SEL = 8'h02;
  localparam logic [7:0] ADDR_TX_COMB_SEL = 8'h03;
  localparam logic [7:0] ADDR_ID          = 8'h04;
  localparam logic [7:0] ADDR_STATUS      = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tthbif_cfg_ctrl.sv
// UART command parser and tap-select register file for tthbif.
// Optional inter-byte timeout and STATUS.TOUT are built when TTHBIF_CFG_TIMEOUT_EN is defined.
module tthbif_cfg_ctrl
  import tthbif_cfg_pkg::*;
#(
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 275000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             rx_data_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             tx_data_ready_i,
  output logic             tx_data_valid_o,
  output logic [7:0]       tx_data_o,
  output logic [SEL_W-1:0] rx_flop_tap_sel_o,
  output logic [SEL_W-1:0] rx_comb_tap_sel_o,
  output logic [SEL_W-1:0] tx_flop_tap_sel_o,
  output logic [SEL_W-1:0] tx_comb_tap_sel_o
);

  localparam int NUM_SEL = 4;

  state_e           state_reg, state_next;
  logic             is_wr_reg, is_wr_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic [7:0]       rd_value;
  logic [SEL_W-1:0] sel_val [NUM_SEL];
  logic             wr_en, drop_evt, tout_evt, status_clr, timeout_hit;
  logic             drop_reg, tout_reg;

  for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_sel
    logic [SEL_W-1:0] sel_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sel_reg <= '1;
      end else if (wr_en && addr_reg[1:0] == 2'(gi)) begin
        sel_reg <= rx_data_i[SEL_W-1:0];
      end
    end
    assign sel_val[gi] = sel_reg;
  end

  // Read data is looked up from the address byte as it arrives.
  always_comb begin
    rd_value = RSP_NAK;
    if (rx_data_i < 8'(NUM_SEL)) begin
      rd_value = 8'(sel_val[rx_data_i[1:0]]);
    end else if (rx_data_i == ADDR_ID) begin
      rd_value = ID_VALUE;
    end else if (rx_data_i == ADDR_STATUS) begin
      rd_value = {6'd0, tout_reg, drop_reg};
    end
  end

  always_comb begin
    state_next   = state_reg;
    is_wr_next   = is_wr_reg;
    addr_next    = addr_reg;
    tx_data_next = tx_data_reg;
    wr_en        = 1'b0;
    drop_evt     = 1'b0;
    tout_evt     = 1'b0;
    status_clr   = 1'b0;
    if (!en_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rx_data_valid_i) begin
            if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
              is_wr_next = (rx_data_i == OP_WRITE);
              state_next = ST_GET_ADDR;
            end else begin
              tx_data_next = RSP_NAK;
              state_next   = ST_RESP;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rx_data_valid_i) begin
            addr_next = rx_data_i;
            if (is_wr_reg) begin
              state_next = ST_GET_DATA;
            end else begin
              tx_data_next = rd_value;
              status_clr   = (rx_data_i == ADDR_STATUS);
              state_next   = ST_RESP;
            end
          end else if (timeout_hit) begin
            tout_evt   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (rx_data_valid_i) begin
            wr_en        = (addr_reg < 8'(NUM_SEL));
            tx_data_next = (addr_reg < 8'(NUM_SEL)) ? RSP_ACK : RSP_NAK;
            state_next   = ST_RESP;
          end else if (timeout_hit) begin
            tout_evt   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          drop_evt = rx_data_valid_i;
          if (tx_data_ready_i) begin
            state_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= ST_IDLE;
      is_wr_reg   <= 1'b0;
      addr_reg    <= 8'h00;
      tx_data_reg <= 8'h00;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      is_wr_reg   <= is_wr_next;
      addr_reg    <= addr_next;
      tx_data_reg <= tx_data_next;
      // A new event outranks the clear from a STATUS read.
      drop_reg    <= drop_evt | (drop_reg & ~status_clr);
    end
  end

`ifdef TTHBIF_CFG_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] timer_reg;
  logic             waiting;

  assign waiting = (state_reg == ST_GET_ADDR) || (state_reg == ST_GET_DATA);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_reg <= '0;
      tout_reg  <= 1'b0;
    end else begin
      if (!en_i || !waiting || rx_data_valid_i) begin
        timer_reg <= '0;
      end else if (timer_reg != '1) begin
        timer_reg <= timer_reg + 1'b1;
      end
      tout_reg <= tout_evt | (tout_reg & ~status_clr);
    end
  end

  assign timeout_hit = waiting && (timer_reg >= CNT_LAST);
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign tout_reg       = 1'b0;
  assign unused_timeout = tout_evt ^ (TIMEOUT_CYCLES > 0);
`endif

  assign tx_data_valid_o   = (state_reg == ST_RESP);
  assign tx_data_o         = tx_data_reg;
  assign rx_flop_tap_sel_o = sel_val[0];
  assign rx_comb_tap_sel_o = sel_val[1];
  assign tx_flop_tap_sel_o = sel_val[2];
  assign tx_comb_tap_sel_o = sel_val[3];

endmodule
